// File: rtl/smem_pkg.sv
// Shared constants and types for the SMEM front end: read RAM geometry,
// the {read_num, line} address layout and the loader FSM states.
package smem_pkg;

    localparam int CL_W        = 512;
    localparam int MAX_READ    = 64;
    localparam int READ_NUM_W  = 6;
    localparam int CL_PER_READ = 4;
    localparam int RAM_AW      = READ_NUM_W + 2;
    localparam int CNT_W       = READ_NUM_W + 3;

    // Read RAM address: four lines per read, read number in the upper bits.
    typedef struct packed {
        logic [READ_NUM_W-1:0] read_num;
        logic [1:0]            line;
    } rd_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_e;

    // Clamp the requested batch size to the RAM capacity.
    function automatic logic [READ_NUM_W:0] clamp_batch(input logic [READ_NUM_W:0] bs);
        logic [READ_NUM_W:0] res;
        if (bs > 7'(MAX_READ)) begin
            res = 7'(MAX_READ);
        end else begin
            res = bs;
        end
        return res;
    endfunction

endpackage

// File: rtl/read_ram_sdp.sv
// Simple dual-port read RAM: 256 x 512, one write port and one registered
// read-first read port. Array contents are never reset.
module read_ram_sdp
    import smem_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [RAM_AW-1:0] waddr,
    input  logic [CL_W-1:0]   wdata,
    input  logic              re,
    input  logic [RAM_AW-1:0] raddr,
    output logic [CL_W-1:0]   rdata
);

    logic [CL_W-1:0] mem_r [0:(1<<RAM_AW)-1];
    logic [CL_W-1:0] rdata_r;

    // Write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read; a same-edge write is not visible (read-first), value holds when idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_r <= {CL_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/read_loader.sv
// Loads a batch of short reads (four cache lines each) into the read RAM,
// flags completion, dispatches completed reads in order and exposes a
// registered random-access read port.
module read_loader
    import smem_pkg::*;
(
    input  logic                  Clk_32UI,
    input  logic                  reset_n,
    input  logic [READ_NUM_W:0]   batch_size,
    input  logic                  load_valid,
    input  logic [CL_W-1:0]       load_data,
    output logic                  read_load_done,
    output logic                  load_overflow,
    output logic                  disp_valid,
    input  logic                  disp_ready,
    output logic [READ_NUM_W-1:0] disp_num,
    output logic                  disp_all,
    input  logic                  rd_en,
    input  logic [READ_NUM_W+1:0] rd_addr,
    output logic [CL_W-1:0]       rd_data
);

    load_state_e         state_r;
    load_state_e         state_nxt_s;
    logic [READ_NUM_W:0] bs_eff_r;
    logic [CNT_W-1:0]    load_cnt_r;
    logic [READ_NUM_W:0] disp_idx_r;
    logic                overflow_r;

    logic [CNT_W-1:0]    target_s;
    logic [READ_NUM_W:0] reads_loaded_s;
    logic                wr_en_s;
    logic                disp_valid_s;
    logic                disp_fire_s;
    rd_addr_t            rd_addr_s;

    assign target_s       = {bs_eff_r, 2'b00};
    assign reads_loaded_s = load_cnt_r[CNT_W-1:2];
    // The count guard keeps load_cnt from passing the batch end, including bs_eff == 0.
    assign wr_en_s        = (state_r == ST_LOAD) && load_valid && (load_cnt_r < target_s);
    assign disp_valid_s   = (state_r != ST_IDLE) && (disp_idx_r < reads_loaded_s)
                            && (disp_idx_r < bs_eff_r);
    assign disp_fire_s    = disp_valid_s && disp_ready;
    assign rd_addr_s      = rd_addr;

    // Next-state logic for the batch load FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_LOAD;
            end
            ST_LOAD: begin
                if (bs_eff_r == 7'd0) begin
                    state_nxt_s = ST_DONE;
                end else if (wr_en_s && ((load_cnt_r + 9'd1) == target_s)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk_32UI) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latch the clamped batch size on leaving IDLE.
    always_ff @(posedge Clk_32UI) begin
        if (!reset_n) begin
            bs_eff_r <= 7'd0;
        end else if (state_r == ST_IDLE) begin
            bs_eff_r <= clamp_batch(batch_size);
        end else begin
            bs_eff_r <= bs_eff_r;
        end
    end

    // Line counter: doubles as the RAM write address.
    always_ff @(posedge Clk_32UI) begin
        if (!reset_n) begin
            load_cnt_r <= 9'd0;
        end else if (wr_en_s) begin
            load_cnt_r <= load_cnt_r + 9'd1;
        end else begin
            load_cnt_r <= load_cnt_r;
        end
    end

    // Sticky overflow: any line offered once the batch is complete.
    always_ff @(posedge Clk_32UI) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
        end else if ((state_r == ST_DONE) && load_valid) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // In-order dispatch index, advanced on each accepted read.
    always_ff @(posedge Clk_32UI) begin
        if (!reset_n) begin
            disp_idx_r <= 7'd0;
        end else if (disp_fire_s) begin
            disp_idx_r <= disp_idx_r + 7'd1;
        end else begin
            disp_idx_r <= disp_idx_r;
        end
    end

    read_ram_sdp u_ram (
        .clk     (Clk_32UI),
        .reset_n (reset_n),
        .we      (wr_en_s),
        .waddr   (load_cnt_r[RAM_AW-1:0]),
        .wdata   (load_data),
        .re      (rd_en),
        .raddr   ({rd_addr_s.read_num, rd_addr_s.line}),
        .rdata   (rd_data)
    );

    // Status outputs are decoded straight from registered state only.
    assign read_load_done = (state_r == ST_DONE);
    assign load_overflow  = overflow_r;
    assign disp_valid     = disp_valid_s;
    assign disp_num       = disp_idx_r[READ_NUM_W-1:0];
    assign disp_all       = (state_r == ST_DONE) && (disp_idx_r == bs_eff_r);

endmodule

// File: doc/read_loader.md
# read_loader

Receives the cache-line stream of short reads that the AFU core fetches in its LOAD_READ phase and writes it into an on-chip read RAM, one 512-bit line per entry and four lines per read. It raises `read_load_done` once the whole batch has landed. It dispatches read numbers in order to the SMEM pipeline as soon as each read is complete. It also serves a registered random-access read port for pipeline lanes. It sits inside the per-batch core, directly downstream of the AFU core's load path, and is reset between batches by the batch reset.

## Interface
Parameters:
- `CL_W`, 512, cache-line width in bits.
- `MAX_READ`, 64, maximum number of reads per batch.
- `READ_NUM_W`, 6, width of a read index.
- `CL_PER_READ`, 4, cache lines per read (fixed).

Ports:
- `Clk_32UI  in  1`  sole clock (200 MHz domain).
- `reset_n  in  1`  synchronous, active-low reset (driven by the batch reset).
- `batch_size  in  READ_NUM_W+1`  number of reads in the batch; stable from reset release until done.
- `load_valid  in  1`  one cache line present on `load_data` this cycle.
- `load_data  in  CL_W`  cache-line payload, arriving in read-major, line-minor order.
- `read_load_done  out  1`  all `4*batch_size` lines written; level signal.
- `load_overflow  out  1`  sticky; a line arrived after done.
- `disp_valid  out  1`  read `disp_num` is fully loaded and offered.
- `disp_ready  in  1`  pipeline accepts the offered read.
- `disp_num  out  READ_NUM_W`  index of the offered read.
- `disp_all  out  1`  every read in the batch has been dispatched.
- `rd_en  in  1`  read-port enable.
- `rd_addr  in  READ_NUM_W+2`  address {read_num, line}.
- `rd_data  out  CL_W`  registered read data.

## Operation
- Reset values:
  - `read_load_done`, `load_overflow`, `disp_valid`, `disp_all` = 0.
  - `disp_num` = 0.
  - `rd_data` = 0.
  - Internal `load_cnt` = 0, `disp_idx` = 0, state = IDLE.
- Latched batch size: `bs_eff` = min(`batch_size`, 64).
- FSM states and transitions:
  - IDLE → LOAD on the first cycle with `reset_n` high; `bs_eff` is latched on that transition.
  - LOAD → DONE when the write that makes `load_cnt == 4*bs_eff` occurs.
  - LOAD → DONE directly if `bs_eff == 0`.
  - DONE holds until reset.
- Write rule:
  - In LOAD, each `load_valid` writes `load_data` to RAM[`load_cnt`] and increments `load_cnt`, which is 9 bits wide.
  - In IDLE, `load_valid` is ignored.
  - In DONE, `load_valid` does not write; it sets `load_overflow`.
- Dispatch:
  - `reads_loaded` = `load_cnt[8:2]`.
  - `disp_valid` = (state != IDLE) & (`disp_idx` < `reads_loaded`) & (`disp_idx` < `bs_eff`).
  - `disp_num` = `disp_idx`.
  - On `disp_valid & disp_ready`, `disp_idx` increments.
  - `disp_all` = (state == DONE) & (`disp_idx == bs_eff`).
- Read port:
  - Read-first semantics.
  - A same-cycle write and read to one address returns the old contents.
  - `rd_data` holds its value when `rd_en` is low.
- A reset mid-load abandons the batch: all counters and flags clear within one cycle. RAM contents are not cleared.

## Timing
- Write latency: line at edge t is readable via `rd_addr` issued at edge t+1; data appears at edge t+2.
- `read_load_done` rises on the cycle after the final line's write edge.
- `disp_valid` for read n rises on the cycle after its 4th line is written.
- Back-to-back accepts give one read per cycle.
- Dispatch and load proceed concurrently; a dispatch handshake and a write in the same cycle are both honoured.
- `disp_valid` is not withdrawn without a handshake, except by reset.
- `bs_eff == 0`: `read_load_done` and `disp_all` are both high on the 2nd cycle after reset release.
- `batch_size` > 64: clamped; the batch completes after 256 lines.

## Structure
- The shared package `smem_pkg` holds:
  - `CL_W`, `MAX_READ`, `READ_NUM_W`, `CL_PER_READ`;
  - the {read_num, line} address struct;
  - the FSM state enum.
- One sub-module, `read_ram_sdp`: simple dual-port, 256×512, one write port, one registered read-first read port.
- The FSM and the counters stay in `read_loader`.

## Test plan
- `batch_size`=2, eight consecutive `load_valid` beats with data = line index:
  - `read_load_done` rises one cycle after beat 8;
  - RAM[0..7] reads back 0..7;
  - `load_overflow` = 0.
- `batch_size`=3, `disp_ready` held high, gapped load (one beat every other cycle):
  - `disp_num` 0, 1, 2 is each offered one cycle after lines 3, 7, 11 are written;
  - `disp_all` = 1 after the third accept.
- `batch_size`=1, `disp_ready` low until done, then high:
  - `disp_valid` stays high with `disp_num`=0 and is stable;
  - accepted on the first ready cycle;
  - `disp_all` rises the next cycle.
- `batch_size`=0:
  - `read_load_done` = `disp_all` = 1 on cycle 2 after reset;
  - a following `load_valid` sets `load_overflow`, and RAM[0] is unchanged.
- `batch_size`=100:
  - clamped to 64; done after 256 beats;
  - the 257th beat sets `load_overflow`.
- Reset asserted after 5 of 8 lines:
  - all outputs return to 0 next cycle;
  - a new 8-line batch then completes normally.
- Simultaneous write and read to the same address:
  - `rd_data` returns the previous contents.
